// File: rtl/controlador_displays.sv
// Four-digit multiplexed seven-segment scan controller with double-buffered data.
// Ports: clk, rst (async high), enable, valor[15:0], pontos[3:0], load -> ack,
//        b0..b3 (decoder nibble, b0=MSB), ponto (decimal point), an[3:0] (active-low).
module controlador_displays #(
  parameter int DIV   = 50000,
  parameter int DWELL = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] valor,
  input  logic [3:0]  pontos,
  input  logic        load,
  output logic        ack,
  output logic        b0,
  output logic        b1,
  output logic        b2,
  output logic        b3,
  output logic        ponto,
  output logic [3:0]  an
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    r_idx;
  logic [PW-1:0] r_presc;
  logic [DW-1:0] r_dwell;
  logic [15:0]   r_pend_v;
  logic [3:0]    r_pend_p;
  logic [15:0]   r_act_v;
  logic [3:0]    r_act_p;
  logic          r_newer;
  logic          r_ack;

  logic          w_tick;
  logic          w_last;
  logic          w_frame_end;
  logic          w_xfer;
  logic [3:0]    w_nib;

  assign w_tick = (r_presc == PW'(DIV - 1));
  assign w_last = (r_dwell == DW'(DWELL - 1));

  assign w_frame_end = (r_state == SHOW) && w_tick
                     && w_last && (r_idx == 2'd3);

  // A disabled scan abandons the frame, so frame-end copies need enable;
  // the idle copy does not.
  assign w_xfer = r_newer
                && ((r_state == IDLE) || (enable && w_frame_end));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_v <= '0;
      r_pend_p <= '0;
      r_act_v  <= '0;
      r_act_p  <= '0;
      r_newer  <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      r_ack <= w_xfer;
      if (w_xfer) begin
        r_act_v <= r_pend_v;
        r_act_p <= r_pend_p;
      end
      // A load on the transfer edge stays pending for the next frame.
      if (load) begin
        r_pend_v <= valor;
        r_pend_p <= pontos;
        r_newer  <= 1'b1;
      end else if (w_xfer) begin
        r_newer  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_presc <= '0;
      r_dwell <= '0;
    end else if (!enable) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_presc <= '0;
      r_dwell <= '0;
    end else begin
      if (r_state == IDLE) begin
        r_presc <= '0;
      end else if (w_tick) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      case (r_state)
        IDLE: begin
          r_state <= BLANK;
          r_idx   <= '0;
          r_dwell <= '0;
        end
        BLANK: begin
          if (w_tick) begin
            r_state <= SHOW;
            r_dwell <= '0;
          end
        end
        SHOW: begin
          if (w_tick) begin
            if (w_last) begin
              r_state <= BLANK;
              r_idx   <= r_idx + 2'd1;
              r_dwell <= '0;
            end else begin
              r_dwell <= r_dwell + DW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_nib = 4'h0;
    case (r_idx)
      2'd0:    w_nib = r_act_v[3:0];
      2'd1:    w_nib = r_act_v[7:4];
      2'd2:    w_nib = r_act_v[11:8];
      default: w_nib = r_act_v[15:12];
    endcase
  end

  assign {b0, b1, b2, b3} = w_nib;
  assign ponto = r_act_p[r_idx];
  assign ack   = r_ack;
  assign an    = (r_state == SHOW) ? ~(4'b0001 << r_idx) : 4'b1111;

endmodule
